// File: rtl/vga_grid_pkg.sv
// -----------------------------------------------------------------------------
// vga_grid_pkg
// Shared definitions for the tile-grid VGA display:
//   - clog2 helper (never returns less than 1, so it can size vectors directly)
//   - colour field widths and the blank (black) colour
//   - clear-sweep FSM state type
//   - VGA_PAL_SLICE macro: picks entry idx out of a packed {r,g,b} palette
// -----------------------------------------------------------------------------
`ifndef VGA_GRID_PKG_SV
`define VGA_GRID_PKG_SV

// Entry idx of a packed palette; entry 0 sits in the least significant bits.
`define VGA_PAL_SLICE(pal, idx) pal[vga_grid_pkg::RGB_W*(idx) +: vga_grid_pkg::RGB_W]

package vga_grid_pkg;

    localparam int CH_W  = 2;          // bits per colour channel
    localparam int RGB_W = 3 * CH_W;   // packed {r,g,b}

    localparam logic [RGB_W-1:0] BLANK_RGB = '0;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_e;

    // Width needed to hold values 0..value-1, minimum 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`endif

// File: rtl/grid_ram_dp.sv
// -----------------------------------------------------------------------------
// grid_ram_dp
// Cell RAM for the tile grid. One write port shared by the clear sweep and the
// host (sweep wins when both request), one independent registered read port.
// A read and a write to the same address on one edge return the old data.
//
// Ports:
//   clk         pixel clock
//   sweep_we    clear-sweep write enable      (priority)
//   sweep_addr  clear-sweep address
//   sweep_data  clear-sweep data
//   host_we     host write enable
//   host_addr   host write address
//   host_data   host write data
//   rd_addr     display read address
//   rd_data     display read data, one cycle after rd_addr
// -----------------------------------------------------------------------------
module grid_ram_dp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          sweep_we,
    input  logic [AW-1:0] sweep_addr,
    input  logic [DW-1:0] sweep_data,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data_q;

    always_comb begin
        wr_en   = sweep_we || host_we;
        wr_addr = sweep_we ? sweep_addr : host_addr;
        wr_data = sweep_we ? sweep_data : host_data;
    end

    // No reset: contents survive rst, and this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_grid_display.sv
// -----------------------------------------------------------------------------
// vga_grid_display
// Maps VGA pixel coordinates onto a GRID_W x GRID_H palette-indexed cell RAM and
// drives 2-bit-per-channel RGB with a fixed 2-cycle latency. Includes a host
// write port, a hardware clear sweep and a blinking (inverting) cursor.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   xcoor, ycoor        current pixel coordinates from the timing generator
//   frame_start         one-cycle pulse per frame (drives the cursor blink)
//   wr_valid/wr_ready   host write handshake; wr_x, wr_y, wr_data = cell/value
//   clear_req, busy     start clear sweep / sweep in progress
//   cursor_en/_x/_y     cursor overlay enable and cell position
//   red, green, blue    registered colour output
//
// Pipeline: edge k registers window flags, RAM address and cursor match;
// edge k+1 reads the RAM; edge k+2 loads the output colour register.
// -----------------------------------------------------------------------------
module vga_grid_display
    import vga_grid_pkg::*;
#(
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 16,
    parameter int CELL_SHIFT   = 4,
    parameter int X0           = 192,
    parameter int Y0           = 112,
    parameter int H_VIS        = 640,
    parameter int V_VIS        = 480,
    parameter int CELL_BITS    = 2,
    parameter logic [RGB_W*(1<<CELL_BITS)-1:0] PALETTE = {6'h3F, 6'h30, 6'h0C, 6'h00},
    parameter logic [RGB_W-1:0]     BORDER_RGB   = 6'h3F,
    parameter logic [CELL_BITS-1:0] CLEAR_VAL    = '0,
    parameter int                   BLINK_FRAMES = 30,
    localparam int XW    = clog2(GRID_W),
    localparam int YW    = clog2(GRID_H),
    localparam int AW    = XW + YW,
    localparam int DEPTH = GRID_W * GRID_H,
    localparam int BW    = clog2(BLINK_FRAMES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           xcoor,
    input  logic [9:0]           ycoor,
    input  logic                 frame_start,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [XW-1:0]        wr_x,
    input  logic [YW-1:0]        wr_y,
    input  logic [CELL_BITS-1:0] wr_data,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic                 cursor_en,
    input  logic [XW-1:0]        cursor_x,
    input  logic [YW-1:0]        cursor_y,
    output logic [CH_W-1:0]      red,
    output logic [CH_W-1:0]      green,
    output logic [CH_W-1:0]      blue
);

    localparam int X_END = X0 + (GRID_W << CELL_SHIFT);
    localparam int Y_END = Y0 + (GRID_H << CELL_SHIFT);

    // ---------------- stage 1: coordinate decode ----------------
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          s1_vis_d, s1_vis_q;
    logic          s1_win_d, s1_win_q;
    logic          s1_cur_d, s1_cur_q;
    logic [AW-1:0] s1_addr_d, s1_addr_q;

    always_comb begin
        // Offsets wrap when outside the window; the window flag masks that.
        cx = XW'((xcoor - 10'(X0)) >> CELL_SHIFT);
        cy = YW'((ycoor - 10'(Y0)) >> CELL_SHIFT);

        s1_vis_d  = (int'(xcoor) < H_VIS) && (int'(ycoor) < V_VIS);
        s1_win_d  = (int'(xcoor) >= X0) && (int'(xcoor) < X_END) &&
                    (int'(ycoor) >= Y0) && (int'(ycoor) < Y_END);
        s1_cur_d  = cursor_en && (cx == cursor_x) && (cy == cursor_y);
        s1_addr_d = {cy, cx};
    end

    // ---------------- stage 2: RAM read, flags delayed ----------------
    logic                 s2_vis_d, s2_vis_q;
    logic                 s2_win_d, s2_win_q;
    logic                 s2_cur_d, s2_cur_q;
    logic [CELL_BITS-1:0] ram_rd_data;

    always_comb begin
        s2_vis_d = s1_vis_q;
        s2_win_d = s1_win_q;
        s2_cur_d = s1_cur_q;
    end

    // ---------------- clear sweep FSM ----------------
    clr_state_e    state_d, state_q;
    logic [AW-1:0] sweep_addr_d, sweep_addr_q;
    logic          busy_d, busy_q;
    logic          sweep_we;
    logic          host_we;

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d      = CLR_SWEEP;
                    sweep_addr_d = '0;
                end
            end
            CLR_SWEEP: begin
                sweep_addr_d = sweep_addr_q + AW'(1);
                if (sweep_addr_q == AW'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
        busy_d = (state_d == CLR_SWEEP);
    end

    assign sweep_we = (state_q == CLR_SWEEP);
    assign busy     = busy_q;
    assign wr_ready = !busy_q;
    assign host_we  = wr_valid && wr_ready;

    grid_ram_dp #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CELL_BITS)
    ) u_ram (
        .clk        (clk),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr_q),
        .sweep_data (CLEAR_VAL),
        .host_we    (host_we),
        .host_addr  ({wr_y, wr_x}),
        .host_data  (wr_data),
        .rd_addr    (s1_addr_q),
        .rd_data    (ram_rd_data)
    );

    // ---------------- cursor blink ----------------
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic          phase_d, phase_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_start) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // ---------------- stage 3: colour select ----------------
    logic [RGB_W-1:0] pal_rgb;
    logic [RGB_W-1:0] rgb_d, rgb_q;

    always_comb begin
        pal_rgb = `VGA_PAL_SLICE(PALETTE, ram_rd_data);
        rgb_d   = BLANK_RGB;
        if (s2_vis_q) begin
            if (!s2_win_q) begin
                rgb_d = BORDER_RGB;
            end else if (s2_cur_q && phase_q) begin
                rgb_d = ~pal_rgb;
            end else begin
                rgb_d = pal_rgb;
            end
        end
    end

    assign red   = rgb_q[2*CH_W +: CH_W];
    assign green = rgb_q[CH_W   +: CH_W];
    assign blue  = rgb_q[0      +: CH_W];

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vis_q     <= 1'b0;
            s1_win_q     <= 1'b0;
            s1_cur_q     <= 1'b0;
            s1_addr_q    <= '0;
            s2_vis_q     <= 1'b0;
            s2_win_q     <= 1'b0;
            s2_cur_q     <= 1'b0;
            state_q      <= CLR_IDLE;
            sweep_addr_q <= '0;
            busy_q       <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            rgb_q        <= BLANK_RGB;
        end else begin
            s1_vis_q     <= s1_vis_d;
            s1_win_q     <= s1_win_d;
            s1_cur_q     <= s1_cur_d;
            s1_addr_q    <= s1_addr_d;
            s2_vis_q     <= s2_vis_d;
            s2_win_q     <= s2_win_d;
            s2_cur_q     <= s2_cur_d;
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            busy_q       <= busy_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            rgb_q        <= rgb_d;
        end
    end

endmodule

// File: tb/tb_vga_grid_display.sv
module tb_vga_grid_display;

    localparam int X0 = 192;
    localparam int Y0 = 112;

    logic       clk;
    logic       rst;
    logic [9:0] xcoor;
    logic [9:0] ycoor;
    logic       frame_start;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_x;
    logic [3:0] wr_y;
    logic [1:0] wr_data;
    logic       clear_req;
    logic       busy;
    logic       cursor_en;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic [5:0] rgb;

    assign rgb = {red, green, blue};

    vga_grid_display dut (
        .clk         (clk),
        .rst         (rst),
        .xcoor       (xcoor),
        .ycoor       (ycoor),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .busy        (busy),
        .cursor_en   (cursor_en),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         x;
        int         y;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, got);
        end
    endtask

    task automatic write_cell(input int cx, input int cy, input logic [1:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_x     = 4'(cx);
        wr_y     = 4'(cy);
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic fill_all(input logic [1:0] d);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_x     = 4'(i % 16);
            wr_y     = 4'(i / 16);
            wr_data  = d;
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Coordinates change after a negedge; the next posedge is edge k,
    // colour is sampled just after edge k+2.
    task automatic scan_pixel(input int x, input int y, output logic [5:0] got);
        @(negedge clk);
        xcoor = 10'(x);
        ycoor = 10'(y);
        repeat (3) @(posedge clk);
        #1 got = rgb;
    endtask

    task automatic scan_cell(input int cx, input int cy, output logic [5:0] got);
        scan_pixel(X0 + 16 * cx + 8, Y0 + 16 * cy + 8, got);
    endtask

    // Cells with linear index < split must show lo_rgb, the rest hi_rgb.
    task automatic scan_cells(input string name, input int split,
                              input logic [5:0] lo_rgb, input logic [5:0] hi_rgb);
        int         bad;
        logic [5:0] got;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            scan_cell(i % 16, i / 16, got);
            if (got !== ((i < split) ? lo_rgb : hi_rgb)) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] got;
        int         busy_cycles;
        int         rdy_bad;

        rst = 1'b1;  xcoor = '0; ycoor = '0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clear_req = 1'b0; cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", int'(rgb), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // ---- full clear sweep over a RAM of 3s ----
        fill_all(2'd3);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        busy_cycles = 0;
        rdy_bad     = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy !== 1'b1) break;
            busy_cycles++;
            if (wr_ready !== 1'b0) rdy_bad++;
            clear_req = (i == 50);                  // must be ignored
            wr_valid  = (i >= 200 && i < 210);      // must not be accepted
            wr_x = '0; wr_y = '0; wr_data = 2'd3;
            @(negedge clk);
        end
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        check("clear_busy_cycles", busy_cycles, 256);
        check("clear_wr_ready_low", rdy_bad, 0);
        check("after_clear_wr_ready", int'(wr_ready), 1);
        scan_cells("clear_all_zero", 256, 6'h00, 6'h00);

        // ---- directed pixel vectors ----
        write_cell(3, 2, 2'd1);
        write_cell(15, 15, 2'd1);
        write_cell(0, 15, 2'd2);

        // latency: switch from border to cell (3,2); one edge short is still border
        scan_pixel(100, 100, got);
        @(negedge clk);
        xcoor = 10'(X0 + 48);
        ycoor = 10'(Y0 + 32);
        repeat (2) @(posedge clk);
        #1 check("latency_k1_old", int'(rgb), 6'h3F);
        @(posedge clk);
        #1 check("latency_k2_new", int'(rgb), 6'h0C);

        vecs[0]  = '{X0 + 48,  Y0 + 32,  6'h0C, "cell_3_2"};
        vecs[1]  = '{X0 + 64,  Y0 + 32,  6'h00, "cell_4_2"};
        vecs[2]  = '{100,      100,      6'h3F, "border_100_100"};
        vecs[3]  = '{650,      10,       6'h00, "blank_650_10"};
        vecs[4]  = '{X0 + 255, Y0 + 255, 6'h0C, "cell_15_15"};
        vecs[5]  = '{X0 + 256, Y0,       6'h3F, "right_of_grid"};
        vecs[6]  = '{X0 - 1,   Y0,       6'h3F, "left_of_grid"};
        vecs[7]  = '{X0,       Y0 - 1,   6'h3F, "above_grid"};
        vecs[8]  = '{X0,       Y0 + 255, 6'h30, "cell_0_15"};
        vecs[9]  = '{10,       479,      6'h3F, "last_visible_row"};
        vecs[10] = '{10,       480,      6'h00, "first_blank_row"};
        vecs[11] = '{639,      0,        6'h3F, "last_visible_col"};
        vecs[12] = '{640,      0,        6'h00, "first_blank_col"};
        for (int i = 0; i < 13; i++) begin
            scan_pixel(vecs[i].x, vecs[i].y, got);
            check(vecs[i].name, int'(got), int'(vecs[i].exp));
        end

        // ---- reset in the middle of a sweep ----
        fill_all(2'd3);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);                 // sweep start edge
        #1 clear_req = 1'b0;
        repeat (100) @(posedge clk);    // cells 0..99 written
        #1 rst = 1'b1;
        frame_start = 1'b1;             // must be ignored under reset
        #1;
        check("rst_mid_sweep_busy", int'(busy), 0);
        check("rst_mid_sweep_wr_ready", int'(wr_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        check("no_resume_busy", int'(busy), 0);
        scan_cells("partial_clear", 100, 6'h00, 6'h3F);

        // ---- cursor blink ----
        write_cell(5, 5, 2'd2);
        write_cell(6, 5, 2'd2);
        cursor_en = 1'b1;
        cursor_x  = 4'd5;
        cursor_y  = 4'd5;
        scan_cell(5, 5, got);
        check("cursor_phase0", int'(got), 6'h30);
        pulse_frames(29);
        scan_cell(5, 5, got);
        check("cursor_29_frames", int'(got), 6'h30);
        pulse_frames(1);
        scan_cell(5, 5, got);
        check("cursor_30_frames", int'(got), 6'h0F);
        scan_cell(6, 5, got);
        check("cursor_neighbour", int'(got), 6'h30);
        cursor_en = 1'b0;
        scan_cell(5, 5, got);
        check("cursor_disabled", int'(got), 6'h30);
        cursor_en = 1'b1;
        pulse_frames(30);
        scan_cell(5, 5, got);
        check("cursor_60_frames", int'(got), 6'h30);

        // ---- same-address read/write on one edge ----
        @(negedge clk);
        xcoor = 10'(X0);
        ycoor = 10'(Y0);
        @(posedge clk);                 // edge k: address registered
        @(negedge clk);
        wr_valid = 1'b1; wr_x = '0; wr_y = '0; wr_data = 2'd2;
        @(posedge clk);                 // edge k+1: read and write cell 0
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk);
        #1 check("same_addr_old", int'(rgb), 6'h00);
        @(posedge clk);
        #1 check("same_addr_new", int'(rgb), 6'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_grid_display.md
# vga_grid_display

Parametrised tile-grid framebuffer display. It maps the VGA pixel coordinates from the timing generator onto a GRID_W x GRID_H cell RAM and produces 2-bit-per-channel RGB with a fixed 2-cycle latency. Cells hold a palette index rather than a single bit. A host-side write port (valid/ready), a hardware clear sweep and a blinking cursor overlay are included. It sits between the VGA timing generator and the RGB output pins, replacing the single-bit 16x16 display.

## Interface
- GRID_W, 16: cells per row; power of two.
- GRID_H, 16: cells per column; power of two.
- CELL_SHIFT, 4: cell size is 2^CELL_SHIFT pixels square.
- X0, 192: left pixel of the grid window.
- Y0, 112: top pixel of the grid window.
- H_VIS, 640: visible width; x >= H_VIS is blanked.
- V_VIS, 480: visible height; y >= V_VIS is blanked.
- CELL_BITS, 2: palette index width per cell.
- PALETTE, {6'h3F,6'h30,6'h0C,6'h00}: entry i = PALETTE[6*i +: 6] = {r,g,b}.
- BORDER_RGB, 6'h3F: colour inside the visible area but outside the grid window.
- CLEAR_VAL, 0: index written by the clear sweep.
- BLINK_FRAMES, 30: frames per cursor phase.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- xcoor  in  10  current pixel x.
- ycoor  in  10  current pixel y.
- frame_start  in  1  one-cycle pulse per frame.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_x  in  clog2(GRID_W)  target cell column.
- wr_y  in  clog2(GRID_H)  target cell row.
- wr_data  in  CELL_BITS  palette index to store.
- clear_req  in  1  start a clear sweep.
- busy  out  1  clear sweep in progress.
- cursor_en  in  1  enable cursor overlay.
- cursor_x  in  clog2(GRID_W)  cursor cell column.
- cursor_y  in  clog2(GRID_H)  cursor cell row.
- red, green, blue  out  2 each  registered colour.

## Operation
- Grid window: X0 <= x < X0 + (GRID_W<<CELL_SHIFT), and the same rule on y with Y0 and GRID_H.
- Cell index: cx = (x-X0)>>CELL_SHIFT, cy = (y-Y0)>>CELL_SHIFT.
- RAM address = {cy, cx}; depth = GRID_W*GRID_H.
- Colour selection, in priority order:
  - Outside the visible area: 0.
  - Outside the grid window: BORDER_RGB.
  - Otherwise: PALETTE[cell].
  - If cursor_en, blink phase = 1 and (cx,cy) == (cursor_x,cursor_y): bitwise NOT of the palette colour.
- Write port: a transfer occurs on a clk edge with wr_valid && wr_ready. The RAM cell is updated at that edge.
- wr_ready = !busy.
- Clear:
  - clear_req sampled while !busy starts the sweep. busy rises next cycle.
  - One cell is written with CLEAR_VAL per cycle, address 0 upward.
  - busy falls after exactly GRID_W*GRID_H cycles.
  - clear_req while busy is ignored.
  - A write accepted in the same cycle as clear_req is performed, then overwritten by the sweep.
- Blink:
  - A counter increments on frame_start.
  - On reaching BLINK_FRAMES-1, the counter wraps to 0 and the phase toggles.
- Reset values: red/green/blue = 0, busy = 0, wr_ready = 1, blink counter = 0, phase = 0. RAM contents are not reset.

## Timing
- Latency: coordinates sampled at edge k; colour valid on outputs after edge k+2.
- Stage 1 (edge k): register window flags, RAM address and cursor match.
- Stage 2 (edge k+1): synchronous RAM read; flags delayed to match.
- Stage 3 (edge k+2): palette lookup and cursor invert into the output register.
- Display read and host write use independent ports; there are no stalls.
- Same-address read and write at one edge: the read returns the old data. The new value is visible one cycle later.
- Reset asserted mid-sweep: busy drops asynchronously. Cells not yet reached keep their old data. No sweep resumes after reset.
- frame_start asserted during reset: ignored.

## Structure
- Include file vga_grid_pkg holds: clog2 helper, colour field widths, blank colour localparam, and the palette-slice macro.
- Sub-module grid_ram_dp:
  - One write port, shared by the clear sweep and the host through a mux; the sweep has priority.
  - One registered read port.
  - Depth GRID_W*GRID_H, width CELL_BITS.
- Top level holds: pipeline registers, clear FSM (IDLE, SWEEP), blink counter and output colour logic.

## Test plan
- Write cell (3,2) = 1 with default PALETTE, then scan pixel (X0+48, Y0+32) -> RGB 6'h0C exactly 2 cycles later. Neighbouring cell (4,2), still 0 -> 6'h00.
- Coordinates (100,100) -> BORDER_RGB. Coordinates (650,10) -> 0. Pixel (X0+255, Y0+255) -> cell (15,15). Pixel (X0+256, Y0) -> border.
- Fill RAM with 3, pulse clear_req -> busy high for 256 cycles, wr_ready low for the same period, then every cell reads 0.
- Assert rst at sweep cycle 100 -> busy = 0 immediately, cells 0-99 = 0, cells 100-255 remain 3.
- Set cursor_en with cursor at (5,5) and cell = 2, pulse frame_start 30 times -> the cursor cell outputs ~6'h30 = 6'h0F. After 30 more pulses -> 6'h30.
- Write cell (0,0) = 2 while reading (0,0) in the same cycle -> that read returns the old value. The next read of (0,0) returns 2.
